line_readout_ctrl: RTL and testbench
====================================

LINE_READOUT_CTRL -- requirements
Module: line_readout_ctrl

Interface
REQ-001 Parameter ADC_WIDHT, default 14, pixel word width.
REQ-002 Parameter PIX_IN_ROW, default 640, pixels per line.
REQ-003 Parameter ROWS_IN_FRAME, default 480, lines per frame.
REQ-004 Parameter RD_LATENCY, default 4, cycles from BUFER_OUT_EN rise to first valid word on BUF_DATA.
REQ-005 CLK  input  1  read-side clock; all logic on falling edge, same clock as the line buffer read port.
REQ-006 RESET  input  1  asynchronous, active-high.
REQ-007 FRAME_START  input  1  one-cycle pulse; new frame begins.
REQ-008 LINE_READY  input  1  one-cycle pulse; writer has completed one line into the active write bank.
REQ-009 BUF_DATA  input  ADC_WIDHT  read data from the line buffer.
REQ-010 BUFER_CHANGE  output  1  bank select shared with the line buffer; reader reads bank opposite to the writer.
REQ-011 BUFER_OUT_EN  output  1  line buffer read enable.
REQ-012 PIX_DATA  output  ADC_WIDHT  registered pixel stream.
REQ-013 PIX_VALID  output  1  PIX_DATA qualifier.
REQ-014 PIX_SOL / PIX_EOL  output  1 each  high with the first / last valid pixel of a line.
REQ-015 PIX_SOF  output  1  high with the first valid pixel of row 0.
REQ-016 OVERRUN  output  1  sticky; LINE_READY arrived while a readout was in progress.
REQ-017 ROW_CNT  output  10  index of the line currently being read out.

Function
REQ-018 FSM states: IDLE, ARM, READ, DRAIN; all transitions on falling CLK.
REQ-019 IDLE: on LINE_READY toggle BUFER_CHANGE and go to ARM; other inputs ignored except FRAME_START.
REQ-020 ARM: exactly one cycle; BUFER_OUT_EN low; then go to READ.
REQ-021 READ: BUFER_OUT_EN high for exactly PIX_IN_ROW consecutive cycles (11-bit pixel counter 0..PIX_IN_ROW-1); then go to DRAIN.
REQ-022 DRAIN: BUFER_OUT_EN low; stay RD_LATENCY+1 cycles so the last word is emitted; then go to IDLE with ROW_CNT advanced.
REQ-023 Valid generation: RD_LATENCY-deep shift of BUFER_OUT_EN; BUF_DATA registered into PIX_DATA when the tap is high.
REQ-024 Latency: BUFER_OUT_EN high on cycles k..k+PIX_IN_ROW-1 -> PIX_VALID high on cycles k+RD_LATENCY+1..k+RD_LATENCY+PIX_IN_ROW, no gaps.
REQ-025 PIX_DATA is 0 whenever PIX_VALID is low.
REQ-026 PIX_SOL on the first and PIX_EOL on the last valid cycle of each line; both high together only if PIX_IN_ROW=1.
REQ-027 PIX_SOF = PIX_SOL while ROW_CNT=0.
REQ-028 ROW_CNT increments at DRAIN exit; wraps from ROWS_IN_FRAME-1 to 0.
REQ-029 FRAME_START: sets ROW_CNT to 0; in ARM/READ/DRAIN it takes effect at DRAIN exit instead of the increment; FRAME_START and LINE_READY in the same cycle in IDLE: row 0 is the line accepted.
REQ-030 LINE_READY in ARM, READ or DRAIN: line dropped, BUFER_CHANGE not toggled, OVERRUN set; OVERRUN cleared only by RESET.
REQ-031 BUFER_CHANGE never toggles outside the IDLE->ARM transition.

Reset
REQ-032 RESET asserted: state IDLE, BUFER_CHANGE=0, BUFER_OUT_EN=0, PIX_DATA=0, all PIX_* flags 0, OVERRUN=0, ROW_CNT=0, counters and valid shift register cleared.
REQ-033 RESET mid-line: outputs go to reset values immediately; the partial line is discarded and no further PIX_VALID for it.
REQ-034 After RESET release, first LINE_READY toggles BUFER_CHANGE to 1.

Verification
REQ-035 PIX_IN_ROW=8, RD_LATENCY=4, BUF_DATA = read index: LINE_READY at cycle 0 -> BUFER_CHANGE=1 at cycle 1, BUFER_OUT_EN cycles 2..9, PIX_VALID cycles 7..14, PIX_DATA 0..7, SOL at 7, EOL at 14, SOF at 7.
REQ-036 Two lines back to back, second LINE_READY after DRAIN exit -> BUFER_CHANGE 1 then 0, ROW_CNT 0 then 1, SOF only on the first line.
REQ-037 LINE_READY during READ -> OVERRUN=1 and stays 1, BUFER_CHANGE unchanged, current line completes all 8 pixels.
REQ-038 ROWS_IN_FRAME=3, four lines -> ROW_CNT 0,1,2,0; SOF on lines 1 and 4.
REQ-039 RESET pulse at the 4th BUFER_OUT_EN cycle -> BUFER_OUT_EN, PIX_VALID, BUFER_CHANGE and ROW_CNT = 0 in the same cycle; no PIX_VALID until the next LINE_READY.
REQ-040 FRAME_START during READ of row 1 -> ROW_CNT=0 after that line's DRAIN; next line carries SOF.

Source files
------------

// File: rtl/line_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_readout_ctrl
// Description : Reads one completed line out of a ping-pong line buffer and
//               turns it into a framed pixel stream. The writer fills one bank
//               while this block reads the other. BUFER_CHANGE flips the banks
//               each time a new line is accepted.
//               All sequential logic runs on the falling edge of CLK, which is
//               the read-port clock of the line buffer.
// Ports       : CLK          - read-side clock (falling-edge active)
//               RESET        - asynchronous, active-high reset
//               FRAME_START  - one-cycle pulse, the next line read is row 0
//               LINE_READY   - one-cycle pulse, the writer finished a line
//               BUF_DATA     - line buffer read data (RD_LATENCY after enable)
//               BUFER_CHANGE - bank select shared with the line buffer
//               BUFER_OUT_EN - line buffer read enable
//               PIX_DATA     - registered pixel word (0 when not valid)
//               PIX_VALID    - PIX_DATA qualifier
//               PIX_SOL/EOL  - first / last valid pixel of a line
//               PIX_SOF      - first valid pixel of row 0
//               OVERRUN      - sticky, a line arrived while one was being read
//               ROW_CNT      - index of the line currently being read out
// Revision    : 1.0 - initial release
// ============================================================================
module line_readout_ctrl #(
  parameter int ADC_WIDHT     = 14,
  parameter int PIX_IN_ROW    = 640,
  parameter int ROWS_IN_FRAME = 480,
  parameter int RD_LATENCY    = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FRAME_START,
  input  logic                 LINE_READY,
  input  logic [ADC_WIDHT-1:0] BUF_DATA,
  output logic                 BUFER_CHANGE,
  output logic                 BUFER_OUT_EN,
  output logic [ADC_WIDHT-1:0] PIX_DATA,
  output logic                 PIX_VALID,
  output logic                 PIX_SOL,
  output logic                 PIX_EOL,
  output logic                 PIX_SOF,
  output logic                 OVERRUN,
  output logic [9:0]           ROW_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [10:0] c_last_pix   = 11'(PIX_IN_ROW - 1);
  // DRAIN lasts RD_LATENCY+1 cycles, so its counter runs 0..RD_LATENCY.
  localparam logic [10:0] c_last_drain = 11'(RD_LATENCY);
  localparam logic [9:0]  c_last_row   = 10'(ROWS_IN_FRAME - 1);

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_cnt;        // pixel index in READ, drain cycle in DRAIN
  logic        r_fs_pend;    // FRAME_START seen while a line was in flight
  logic        w_read;
  logic        w_accept;
  logic        w_drain_exit;

  // Per-stage tag {sol, eol, en} travelling alongside the read request so
  // the line markers line up with the returning data.
  logic [2:0]  r_pipe [RD_LATENCY];
  logic [2:0]  w_tap;

  assign w_read       = (r_state == S_READ);
  assign w_accept     = (r_state == S_IDLE) && LINE_READY;
  assign w_drain_exit = (r_state == S_DRAIN) && (r_cnt == c_last_drain);
  assign w_tap        = r_pipe[RD_LATENCY-1];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    BUFER_OUT_EN = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (LINE_READY) begin
          w_next = S_ARM;
        end
      end
      S_ARM: begin
        w_next = S_READ;
      end
      S_READ: begin
        BUFER_OUT_EN = 1'b1;
        if (r_cnt == c_last_pix) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_last_drain) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counter restarts on every state change, so each state sees 0..N.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (r_state != w_next) begin
      r_cnt <= '0;
    end else if ((r_state == S_READ) || (r_state == S_DRAIN)) begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bank select, overrun flag and row tracking
  // --------------------------------------------------------------------------
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      BUFER_CHANGE <= 1'b0;
      OVERRUN      <= 1'b0;
      ROW_CNT      <= '0;
      r_fs_pend    <= 1'b0;
    end else begin
      if (w_accept) begin
        BUFER_CHANGE <= ~BUFER_CHANGE;
      end

      // A line offered while busy is lost; the writer must be told.
      if (LINE_READY && (r_state != S_IDLE)) begin
        OVERRUN <= 1'b1;
      end

      // A frame start during a readout must not retag the line in flight,
      // so it is remembered and applied when that line finishes.
      if (w_drain_exit) begin
        r_fs_pend <= 1'b0;
      end else if (FRAME_START && (r_state != S_IDLE)) begin
        r_fs_pend <= 1'b1;
      end

      if ((r_state == S_IDLE) && FRAME_START) begin
        ROW_CNT <= '0;
      end else if (w_drain_exit) begin
        if (r_fs_pend || FRAME_START || (ROW_CNT == c_last_row)) begin
          ROW_CNT <= '0;
        end else begin
          ROW_CNT <= ROW_CNT + 10'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-latency alignment and output register
  // --------------------------------------------------------------------------
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {w_read && (r_cnt == 11'd0),
                    w_read && (r_cnt == c_last_pix),
                    w_read};
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      PIX_DATA  <= '0;
      PIX_VALID <= 1'b0;
      PIX_SOL   <= 1'b0;
      PIX_EOL   <= 1'b0;
      PIX_SOF   <= 1'b0;
    end else if (w_tap[0]) begin
      PIX_DATA  <= BUF_DATA;
      PIX_VALID <= 1'b1;
      PIX_SOL   <= w_tap[2];
      PIX_EOL   <= w_tap[1];
      // ROW_CNT only moves after the last word of the line is out.
      PIX_SOF   <= w_tap[2] && (ROW_CNT == 10'd0);
    end else begin
      PIX_DATA  <= '0;
      PIX_VALID <= 1'b0;
      PIX_SOL   <= 1'b0;
      PIX_EOL   <= 1'b0;
      PIX_SOF   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_readout_ctrl
// Description : Self-checking bench for line_readout_ctrl with 8 pixels per
//               line, 3 lines per frame and a 4-cycle buffer read latency.
//               A behavioural line buffer returns (bank*100 + read index).
//               Each accepted line pushes its expected pixels to a
//               scoreboard that is popped whenever PIX_VALID is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_readout_ctrl;

  localparam int ADC_WIDHT     = 14;
  localparam int PIX_IN_ROW    = 8;
  localparam int ROWS_IN_FRAME = 3;
  localparam int RD_LATENCY    = 4;

  logic                 CLK;
  logic                 RESET;
  logic                 FRAME_START;
  logic                 LINE_READY;
  logic [ADC_WIDHT-1:0] BUF_DATA;
  logic                 BUFER_CHANGE;
  logic                 BUFER_OUT_EN;
  logic [ADC_WIDHT-1:0] PIX_DATA;
  logic                 PIX_VALID;
  logic                 PIX_SOL;
  logic                 PIX_EOL;
  logic                 PIX_SOF;
  logic                 OVERRUN;
  logic [9:0]           ROW_CNT;

  line_readout_ctrl #(
    .ADC_WIDHT    (ADC_WIDHT),
    .PIX_IN_ROW   (PIX_IN_ROW),
    .ROWS_IN_FRAME(ROWS_IN_FRAME),
    .RD_LATENCY   (RD_LATENCY)
  ) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FRAME_START (FRAME_START),
    .LINE_READY  (LINE_READY),
    .BUF_DATA    (BUF_DATA),
    .BUFER_CHANGE(BUFER_CHANGE),
    .BUFER_OUT_EN(BUFER_OUT_EN),
    .PIX_DATA    (PIX_DATA),
    .PIX_VALID   (PIX_VALID),
    .PIX_SOL     (PIX_SOL),
    .PIX_EOL     (PIX_EOL),
    .PIX_SOF     (PIX_SOF),
    .OVERRUN     (OVERRUN),
    .ROW_CNT     (ROW_CNT)
  );

  // Cycles begin at falling edges; the bench drives and samples on rising.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(negedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit exp_ovr  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Line buffer model: word read in cycle k appears on BUF_DATA in cycle
  // k+RD_LATENCY. The reader reads the bank opposite to BUFER_CHANGE.
  // --------------------------------------------------------------------------
  logic [ADC_WIDHT-1:0] mq [0:RD_LATENCY];
  int rd_idx = 0;
  initial begin
    for (int i = 0; i <= RD_LATENCY; i++) mq[i] = '0;
    BUF_DATA = '0;
  end
  always @(posedge CLK) begin
    for (int i = RD_LATENCY; i > 0; i--) mq[i] = mq[i-1];
    if (BUFER_OUT_EN) begin
      mq[0]  = ADC_WIDHT'((BUFER_CHANGE ? 0 : 100) + rd_idx);
      rd_idx = rd_idx + 1;
    end else begin
      mq[0]  = '0;
      rd_idx = 0;
    end
    BUF_DATA = mq[RD_LATENCY];
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int data;
    bit sol;
    bit eol;
    bit sof;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pe;

  always @(posedge CLK) begin
    if (PIX_VALID) begin
      if (sb.size() == 0) begin
        chk("unexpected_pix_valid", 1, 0);
      end else begin
        pe = sb.pop_front();
        chk("pix_cycle", cyc, pe.cyc);
        chk("pix_data", int'(PIX_DATA), pe.data);
        chk("pix_sol", int'(PIX_SOL), int'(pe.sol));
        chk("pix_eol", int'(PIX_EOL), int'(pe.eol));
        chk("pix_sof", int'(PIX_SOF), int'(pe.sof));
      end
    end else if (!RESET) begin
      chk("idle_pix_outputs", int'({PIX_DATA, PIX_SOL, PIX_EOL, PIX_SOF}), 0);
    end
  end

  // --------------------------------------------------------------------------
  // One line: LINE_READY in relative cycle 0, optional extra LINE_READY /
  // FRAME_START pulses later in the line, checks on every cycle through 15.
  // --------------------------------------------------------------------------
  task automatic run_line(input bit fs_now, input int lr_at, input int fs_at,
                          input int row, input bit bank, input int next_row);
    int   c;
    exp_t e;
    @(posedge CLK);
    c           = cyc;
    LINE_READY  = 1'b1;
    FRAME_START = fs_now;
    for (int i = 0; i < PIX_IN_ROW; i++) begin
      e.data = (bank ? 0 : 100) + i;
      e.sol  = (i == 0);
      e.eol  = (i == PIX_IN_ROW - 1);
      e.sof  = (i == 0) && (row == 0);
      e.cyc  = c + RD_LATENCY + 3 + i;
      sb.push_back(e);
    end
    if (lr_at > 0) exp_ovr = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(posedge CLK);
      LINE_READY  = (j == lr_at);
      FRAME_START = (j == fs_at);
      chk("bufer_out_en", int'(BUFER_OUT_EN), int'(j >= 2 && j <= 9));
      if (j == 1) begin
        chk("bufer_change", int'(BUFER_CHANGE), int'(bank));
      end
      if (j < 15) begin
        chk("row_cnt_line", int'(ROW_CNT), row);
      end else begin
        chk("row_cnt_next", int'(ROW_CNT), next_row);
        chk("bufer_change_hold", int'(BUFER_CHANGE), int'(bank));
        chk("overrun", int'(OVERRUN), int'(exp_ovr));
      end
    end
  endtask

  typedef struct {
    bit fs_now;
    int lr_at;
    int fs_at;
    int row;
    bit bank;
    int next_row;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //          fs lr fs_at row bank next
    tbl[0] = '{1, 0, 0, 0, 1'b1, 1};   // first line after reset, frame start
    tbl[1] = '{0, 0, 0, 1, 1'b0, 2};   // back to back, bank flips back
    tbl[2] = '{0, 0, 0, 2, 1'b1, 0};   // last row wraps
    tbl[3] = '{0, 0, 0, 0, 1'b0, 1};   // row 0 again, SOF
    tbl[4] = '{0, 0, 0, 1, 1'b1, 2};
    tbl[5] = '{0, 5, 0, 2, 1'b0, 0};   // LINE_READY during READ: overrun
    tbl[6] = '{0, 0, 0, 0, 1'b1, 1};
    tbl[7] = '{0, 0, 5, 1, 1'b0, 0};   // FRAME_START during READ of row 1
    tbl[8] = '{0, 0, 0, 0, 1'b1, 1};   // follows frame start: SOF
    tbl[9] = '{0, 0, 0, 1, 1'b0, 2};

    RESET       = 1'b1;
    FRAME_START = 1'b0;
    LINE_READY  = 1'b0;
    repeat (3) @(posedge CLK);
    chk("rst_bufer_change", int'(BUFER_CHANGE), 0);
    chk("rst_bufer_out_en", int'(BUFER_OUT_EN), 0);
    chk("rst_pix_valid", int'(PIX_VALID), 0);
    chk("rst_pix_data", int'(PIX_DATA), 0);
    chk("rst_flags", int'({PIX_SOL, PIX_EOL, PIX_SOF}), 0);
    chk("rst_overrun", int'(OVERRUN), 0);
    chk("rst_row_cnt", int'(ROW_CNT), 0);
    RESET = 1'b0;
    repeat (3) @(posedge CLK);

    for (int t = 0; t < 10; t++) begin
      run_line(tbl[t].fs_now, tbl[t].lr_at, tbl[t].fs_at,
               tbl[t].row, tbl[t].bank, tbl[t].next_row);
    end

    // Reset in the middle of a line (4th read-enable cycle).
    @(posedge CLK);
    LINE_READY = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge CLK);
      LINE_READY = 1'b0;
    end
    chk("pre_rst_bufer_out_en", int'(BUFER_OUT_EN), 1);
    chk("pre_rst_bufer_change", int'(BUFER_CHANGE), 1);
    chk("pre_rst_row_cnt", int'(ROW_CNT), 2);
    RESET = 1'b1;
    #1;
    chk("mid_rst_bufer_out_en", int'(BUFER_OUT_EN), 0);
    chk("mid_rst_pix_valid", int'(PIX_VALID), 0);
    chk("mid_rst_bufer_change", int'(BUFER_CHANGE), 0);
    chk("mid_rst_row_cnt", int'(ROW_CNT), 0);
    chk("mid_rst_overrun", int'(OVERRUN), 0);
    repeat (2) @(posedge CLK);
    RESET   = 1'b0;
    exp_ovr = 1'b0;
    // Any PIX_VALID here is flagged by the scoreboard (queue is empty).
    repeat (20) @(posedge CLK);

    // First line after reset must switch to bank 1 and be row 0.
    run_line(1'b0, 0, 0, 0, 1'b1, 1);

    repeat (12) @(posedge CLK);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
